// File: rtl/uart_boot_loader_if.sv
// Boot loader signal bundle: UART byte input, memory word write port and SoC control/status.
interface uart_boot_loader_if #(
    parameter int MEMORY_SIZE = 16384
);
    localparam int AW = $clog2(MEMORY_SIZE / 4);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          halt;
    logic          soc_rst;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_wdata, halt, soc_rst, busy, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_wdata, halt, soc_rst, busy, done, error
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Serial boot controller: loads a checksummed program image from a UART byte stream into
// SoC memory inside a boot window, then releases the core through a timed reset pulse.
module uart_boot_loader #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int MEMORY_SIZE  = 16384,
    parameter int BOOT_WINDOW  = CLOCK_FREQ / 2,
    parameter int BYTE_TIMEOUT = CLOCK_FREQ / 100,
    parameter int RST_CYCLES   = 16
) (
    input logic                clk,
    input logic                rst,
    uart_boot_loader_if.master bus
);
    localparam int          AW        = $clog2(MEMORY_SIZE / 4);
    localparam logic [15:0] MAX_WORDS = 16'(MEMORY_SIZE / 4);
    localparam logic [7:0]  MAGIC     = 8'hB0;

    typedef enum logic [2:0] {
        WINDOW, LEN0, LEN1, DATA, CSUM, ERR, RUN_RST, RUN
    } state_t;

    state_t        state_q;
    logic [31:0]   cnt_q;
    logic [7:0]    lenLo_q;
    logic [15:0]   remain_q;
    logic [1:0]    byteIdx_q;
    logic [31:0]   asm_q;
    logic [7:0]    sum_q;
    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [31:0]   memWdata_q;
    logic          halt_q;
    logic          socRst_q;
    logic          done_q;
    logic          error_q;

    logic [15:0]   count_d;
    logic [7:0]    sum_d;
    logic [31:0]   word_d;
    logic          magic_d;

    assign count_d = {bus.rx_data, lenLo_q};
    assign sum_d   = sum_q + bus.rx_data;
    assign word_d  = {bus.rx_data, asm_q[31:8]};
    assign magic_d = bus.rx_valid && (bus.rx_data == MAGIC);

    // One counter is shared: window length, inter-byte idle time, reset pulse length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WINDOW;
            cnt_q      <= '0;
            lenLo_q    <= '0;
            remain_q   <= '0;
            byteIdx_q  <= '0;
            asm_q      <= '0;
            sum_q      <= '0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            halt_q     <= 1'b1;
            socRst_q   <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            memWe_q <= 1'b0;
            if (memWe_q) begin
                memAddr_q <= memAddr_q + AW'(1);
            end

            case (state_q)
                WINDOW, ERR: begin
                    socRst_q <= 1'b0;
                    if (magic_d) begin
                        state_q   <= LEN0;
                        cnt_q     <= '0;
                        memAddr_q <= '0;
                        sum_q     <= '0;
                        byteIdx_q <= '0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                    end else if (state_q == WINDOW) begin
                        if (cnt_q == 32'(BOOT_WINDOW - 1)) begin
                            state_q  <= RUN_RST;
                            socRst_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                end

                LEN0, LEN1, DATA, CSUM: begin
                    if (bus.rx_valid) begin
                        cnt_q <= '0;
                        case (state_q)
                            LEN0: begin
                                lenLo_q <= bus.rx_data;
                                state_q <= LEN1;
                            end
                            LEN1: begin
                                remain_q <= count_d;
                                if (count_d == 16'd0) begin
                                    state_q <= CSUM;
                                end else if (count_d > MAX_WORDS) begin
                                    state_q <= ERR;
                                    error_q <= 1'b1;
                                end else begin
                                    state_q <= DATA;
                                end
                            end
                            DATA: begin
                                asm_q     <= word_d;
                                sum_q     <= sum_d;
                                byteIdx_q <= byteIdx_q + 2'd1;
                                if (byteIdx_q == 2'd3) begin
                                    memWe_q    <= 1'b1;
                                    memWdata_q <= word_d;
                                    remain_q   <= remain_q - 16'd1;
                                    if (remain_q == 16'd1) begin
                                        state_q <= CSUM;
                                    end
                                end
                            end
                            default: begin
                                if (sum_d == 8'd0) begin
                                    state_q  <= RUN_RST;
                                    socRst_q <= 1'b1;
                                    done_q   <= 1'b1;
                                end else begin
                                    state_q <= ERR;
                                    error_q <= 1'b1;
                                end
                            end
                        endcase
                    end else if (cnt_q == 32'(BYTE_TIMEOUT)) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                RUN_RST: begin
                    if (cnt_q == 32'(RST_CYCLES - 1)) begin
                        state_q  <= RUN;
                        socRst_q <= 1'b0;
                        halt_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                default: begin
                    halt_q   <= 1'b0;
                    socRst_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_we    = memWe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.halt      = halt_q;
    assign bus.soc_rst   = socRst_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.busy      = (state_q == LEN0) || (state_q == LEN1) ||
                           (state_q == DATA) || (state_q == CSUM);
endmodule
